remote_cmd_sender: RTL and testbench

Host-side counterpart of the on-chip command interface: accepts a 16-bit command and serializes it on TX as two 8N1 UART frames, high byte first. Concurrently deserializes RX into 8-bit response bytes (acks/status) from the device side. Used as the remote/host model in the full-chip bench and as the bridge from a host front end to the design's UART port. Contains its own baud-rate transmitter and receiver; no external UART.

---
 rtl/remote_cmd_sender.sv | 162 ++++++++++++++++
 tb/tb_remote_cmd_sender.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/remote_cmd_sender.sv
// remote_cmd_sender
// Host-side UART bridge. A 16-bit command goes out on TX as two 8N1 frames,
// high byte first, back to back. RX is deserialized independently into
// 8-bit response bytes. Both directions share only the bit period.
module remote_cmd_sender #(
   parameter int BAUD_DIV = 2604
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cmd,
   input  logic        snd_cmd,
   output logic        busy,
   output logic        cmd_snt,
   output logic [7:0]  resp,
   output logic        resp_rdy,
   input  logic        clr_resp_rdy,
   input  logic        RX,
   output logic        TX
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

   typedef enum logic [1:0] {TX_IDLE, SEND_HIGH, SEND_LOW} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // ---------------- transmit side ----------------
   tx_state_t       tx_state;
   logic [7:0]      hold_low;   // low byte waits here while the high byte is on the wire
   logic [8:0]      tx_shift;   // remaining data bits plus the stop bit, LSB leaves first
   logic [CW-1:0]   tx_baud;
   logic [3:0]      tx_bit;     // 0 = start bit, 1..8 = data, 9 = stop

   // TX framer: start bit is driven on the acceptance edge, so TX is already low in cycle k+1
   // NOTE: every register in a clocked block uses <= so all of them see pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         hold_low <= 8'h00;
         tx_shift <= 9'h1ff;
         tx_baud  <= '0;
         tx_bit   <= 4'd0;
         TX       <= 1'b1;
         busy     <= 1'b0;
         cmd_snt  <= 1'b0;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (snd_cmd) begin
                  hold_low <= cmd[7:0];
                  tx_shift <= {1'b1, cmd[15:8]};
                  tx_baud  <= '0;
                  tx_bit   <= 4'd0;
                  TX       <= 1'b0;
                  busy     <= 1'b1;
                  cmd_snt  <= 1'b0;
                  tx_state <= SEND_HIGH;
               end
            end
            default: begin
               if (tx_baud != BAUD_LAST) begin
                  tx_baud <= tx_baud + 1'b1;
               end else begin
                  tx_baud <= '0;
                  if (tx_bit != 4'd9) begin
                     TX       <= tx_shift[0];
                     tx_shift <= {1'b1, tx_shift[8:1]};
                     tx_bit   <= tx_bit + 4'd1;
                  end else if (tx_state == SEND_HIGH) begin
                     // high-byte stop bit done: low-byte start bit follows with no gap
                     TX       <= 1'b0;
                     tx_shift <= {1'b1, hold_low};
                     tx_bit   <= 4'd0;
                     tx_state <= SEND_LOW;
                  end else begin
                     TX       <= 1'b1;
                     busy     <= 1'b0;
                     cmd_snt  <= 1'b1;
                     tx_state <= TX_IDLE;
                  end
               end
            end
         endcase
      end
   end

   // ---------------- receive side ----------------
   logic            rx_s1, rx_s2, rx_prev;
   rx_state_t       rx_state;
   logic [7:0]      rx_shift;
   logic [CW-1:0]   rx_baud;
   logic [3:0]      rx_bit;

   // RX synchronizer plus one history flop for falling-edge detection; idles high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= RX;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   // RX deframer: half-bit to confirm start, then one sample per bit period at mid-bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state <= RX_IDLE;
         rx_shift <= 8'h00;
         rx_baud  <= '0;
         rx_bit   <= 4'd0;
         resp     <= 8'h00;
         resp_rdy <= 1'b0;
      end else begin
         // NOTE: the good-byte set below is a later assignment in the same block, so it overrides this clear.
         if (clr_resp_rdy) resp_rdy <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rx_prev && !rx_s2) begin
                  rx_baud  <= '0;
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (rx_baud != HALF_LAST) begin
                  rx_baud <= rx_baud + 1'b1;
               end else begin
                  rx_baud  <= '0;
                  rx_bit   <= 4'd0;
                  rx_state <= rx_s2 ? RX_IDLE : RX_DATA;   // high here means a glitch
               end
            end
            RX_DATA: begin
               if (rx_baud != BAUD_LAST) begin
                  rx_baud <= rx_baud + 1'b1;
               end else begin
                  rx_baud  <= '0;
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  if (rx_bit == 4'd7) rx_state <= RX_STOP;
                  else                rx_bit   <= rx_bit + 4'd1;
               end
            end
            default: begin
               if (rx_baud != BAUD_LAST) begin
                  rx_baud <= rx_baud + 1'b1;
               end else begin
                  rx_baud  <= '0;
                  rx_state <= RX_IDLE;
                  if (rx_s2) begin   // framing error leaves resp untouched
                     resp     <= rx_shift;
                     resp_rdy <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_remote_cmd_sender.sv
// tb_remote_cmd_sender
// Scoreboard bench: stimulus pushes expected bytes into queues, independent
// monitors decode TX and watch resp/resp_rdy and compare against them.
module tb_remote_cmd_sender;

   localparam int BD = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cmd;
   logic        snd_cmd;
   logic        busy;
   logic        cmd_snt;
   logic [7:0]  resp;
   logic        resp_rdy;
   logic        clr_resp_rdy;
   logic        RX;
   logic        TX;

   remote_cmd_sender #(.BAUD_DIV(BD)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd          (cmd),
      .snd_cmd      (snd_cmd),
      .busy         (busy),
      .cmd_snt      (cmd_snt),
      .resp         (resp),
      .resp_rdy     (resp_rdy),
      .clr_resp_rdy (clr_resp_rdy),
      .RX           (RX),
      .TX           (TX)
   );

   always #5 clk = ~clk;

   // edge counter: value after a rising edge is that edge's number
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]  tx_exp[$];
   logic [7:0]  rx_exp[$];
   int unsigned tx_done_edge = 0;   // model: sender is free on edges strictly after this

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name, input logic [31:0] act);
      n_cmp++;
      n_err++;
      $display("FAIL %s: got 0x%0h with nothing expected (t=%0t)", name, act, $time);
   endtask

   // reference model for command acceptance; call at a falling edge before the request edge
   task automatic tx_model(input logic [15:0] c);
      int unsigned e;
      e = cyc + 1;
      if (e > tx_done_edge) begin
         tx_exp.push_back(c[15:8]);
         tx_exp.push_back(c[7:0]);
         tx_done_edge = e + 20 * BD;
      end
   endtask

   task automatic pulse_cmd(input logic [15:0] c);
      tx_model(c);
      cmd     = c;
      snd_cmd = 1'b1;
      @(negedge clk);
      snd_cmd = 1'b0;
      cmd     = 16'($urandom);
   endtask

   task automatic wait_neg(input int n, output bit ab);
      ab = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (rst) begin
            ab = 1'b1;
            break;
         end
      end
   endtask

   // drive one 8N1 frame on RX; abandons the frame if reset appears
   task automatic rx_send(input logic [7:0] b, input bit stop_ok, output bit ab);
      logic [9:0] fr;
      fr = {stop_ok, b, 1'b0};
      if (stop_ok) rx_exp.push_back(b);
      ab = 1'b0;
      for (int i = 0; i < 10; i++) begin
         RX = fr[i];
         for (int j = 0; j < BD; j++) begin
            @(negedge clk);
            if (rst) begin
               ab = 1'b1;
               RX = 1'b1;
               return;
            end
         end
      end
      RX = 1'b1;
   endtask

   task automatic pulse_clr();
      clr_resp_rdy = 1'b1;
      @(negedge clk);
      clr_resp_rdy = 1'b0;
   endtask

   task automatic wait_tx_done();
      for (int i = 0; i < 30 * BD; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      check("tx_done_timeout", busy, 1'b0);
   endtask

   // cycle-exact TX waveform check for one command; optionally pokes ignored requests
   task automatic wave_test(input logic [15:0] c, input bit inject);
      logic [19:0] frm;
      int wave_bad, busy_bad, snt_bad, first_bad;
      frm = {1'b1, c[7:0], 1'b0, 1'b1, c[15:8], 1'b0};
      wave_bad = 0; busy_bad = 0; snt_bad = 0; first_bad = -1;
      tx_model(c);
      cmd     = c;
      snd_cmd = 1'b1;
      for (int m = 1; m <= 20 * BD; m++) begin
         @(negedge clk);
         if (m == 1) begin
            snd_cmd = 1'b0;
            cmd     = ~c;
         end
         if (TX !== frm[(m - 1) / BD]) begin
            wave_bad++;
            if (first_bad < 0) first_bad = m;
         end
         if (busy !== 1'b1)    busy_bad++;
         if (cmd_snt !== 1'b0) snt_bad++;
         if (inject && m == 50) begin
            tx_model(16'h1234);
            cmd     = 16'h1234;
            snd_cmd = 1'b1;
         end
         if (inject && m == 51) snd_cmd = 1'b0;
         if (inject && m == 20 * BD) begin
            tx_model(16'hBEEF);
            cmd     = 16'hBEEF;
            snd_cmd = 1'b1;
         end
      end
      if (wave_bad != 0) $display("note: first TX wave difference at cycle %0d", first_bad);
      check("tx_wave_bad_cycles", wave_bad, 0);
      check("busy_low_during_frame", busy_bad, 0);
      check("cmd_snt_early", snt_bad, 0);
      @(negedge clk);
      snd_cmd = 1'b0;
      check("cmd_snt_at_end", cmd_snt, 1'b1);
      check("busy_at_end", busy, 1'b0);
      check("tx_idle_at_end", TX, 1'b1);
   endtask

   // TX monitor: decode frames at mid-bit and compare against the scoreboard
   initial begin
      logic [7:0] b;
      bit ab;
      forever begin
         @(negedge clk);
         if (!rst && TX === 1'b0) begin
            wait_neg(BD / 2, ab);
            if (ab) continue;
            if (TX !== 1'b0) begin
               fail("tx_start_glitch", TX);
               continue;
            end
            for (int i = 0; i < 8 && !ab; i++) begin
               wait_neg(BD, ab);
               b[i] = TX;
            end
            if (ab) continue;
            wait_neg(BD, ab);
            if (ab) continue;
            check("tx_stop_bit", TX, 1'b1);
            if (tx_exp.size() == 0) fail("tx_unexpected_byte", b);
            else check("tx_byte", b, tx_exp.pop_front());
         end
      end
   end

   // RX monitor: any new good byte shows as a rising resp_rdy or a changed resp
   initial begin
      logic [7:0] prev_resp = 8'h00;
      logic       prev_rdy  = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && ((resp_rdy && !prev_rdy) || resp !== prev_resp)) begin
            check("rx_rdy_with_byte", resp_rdy, 1'b1);
            if (rx_exp.size() == 0) fail("rx_unexpected_byte", resp);
            else check("rx_byte", resp, rx_exp.pop_front());
         end
         prev_resp = resp;
         prev_rdy  = resp_rdy;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ab;
      bit got;
      rst = 1'b1; snd_cmd = 1'b0; clr_resp_rdy = 1'b0; RX = 1'b1; cmd = 16'h0000;
      repeat (3) @(negedge clk);
      check("rst_tx", TX, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_cmd_snt", cmd_snt, 1'b0);
      check("rst_resp", resp, 8'h00);
      check("rst_resp_rdy", resp_rdy, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // exact framing, ignored mid-frame and completion-edge requests
      wave_test(16'hA53C, 1'b1);
      repeat (3) @(negedge clk);

      // new command after completion clears cmd_snt on acceptance
      pulse_cmd(16'h00FF);
      check("cmd_snt_cleared", cmd_snt, 1'b0);
      check("busy_after_accept", busy, 1'b1);
      wait_tx_done();

      // good RX byte, then clear
      rx_send(8'hA5, 1'b1, ab);
      repeat (2 * BD) @(negedge clk);
      check("rx_a5_resp", resp, 8'hA5);
      check("rx_a5_rdy", resp_rdy, 1'b1);
      pulse_clr();
      check("rx_clr_rdy", resp_rdy, 1'b0);

      // framing error and glitch: nothing changes
      rx_send(8'hC3, 1'b0, ab);
      repeat (2 * BD) @(negedge clk);
      RX = 1'b0;
      repeat (2) @(negedge clk);
      RX = 1'b1;
      repeat (4 * BD) @(negedge clk);
      check("rx_bad_resp_kept", resp, 8'hA5);
      check("rx_bad_rdy_kept", resp_rdy, 1'b0);

      // overrun: back-to-back bytes without clearing
      rx_send(8'h11, 1'b1, ab);
      rx_send(8'h22, 1'b1, ab);
      repeat (2 * BD) @(negedge clk);
      check("rx_overrun_resp", resp, 8'h22);
      check("rx_overrun_rdy", resp_rdy, 1'b1);
      pulse_clr();

      // clear held across the arrival edge: the set must win
      clr_resp_rdy = 1'b1;
      got = 1'b0;
      fork
         rx_send(8'h5A, 1'b1, ab);
         begin
            for (int i = 0; i < 14 * BD; i++) begin
               @(negedge clk);
               if (resp === 8'h5A) begin
                  got = 1'b1;
                  break;
               end
            end
            check("rx_collision_seen", got, 1'b1);
            check("rx_collision_rdy", resp_rdy, 1'b1);
         end
      join
      clr_resp_rdy = 1'b0;
      repeat (2 * BD) @(negedge clk);

      // randomized full duplex traffic
      fork
         for (int n = 0; n < 6; n++) begin
            repeat ($urandom_range(0, 250)) @(negedge clk);
            pulse_cmd(16'($urandom));
         end
         for (int n = 0; n < 8; n++) begin
            bit ab_r;
            repeat ($urandom_range(0, 40)) @(negedge clk);
            rx_send(8'($urandom), $urandom_range(0, 4) != 0, ab_r);
            repeat (2 * BD) @(negedge clk);
            pulse_clr();
         end
      join
      wait_tx_done();
      repeat (2) @(negedge clk);

      // reset in the middle of the high byte while a byte is arriving
      pulse_cmd(16'h9D62);
      fork
         begin
            bit ab_x;
            rx_send(8'h77, 1'b1, ab_x);
         end
      join_none
      repeat (30) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_tx", TX, 1'b1);
      check("midrst_busy", busy, 1'b0);
      check("midrst_cmd_snt", cmd_snt, 1'b0);
      check("midrst_resp", resp, 8'h00);
      check("midrst_rdy", resp_rdy, 1'b0);
      tx_exp.delete();
      rx_exp.delete();
      tx_done_edge = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      wait fork;
      repeat (2 * BD) @(negedge clk);
      check("post_rst_tx_idle", TX, 1'b1);
      wave_test(16'h5EC1, 1'b0);

      repeat (4 * BD) @(negedge clk);
      check("tx_queue_drained", tx_exp.size(), 0);
      check("rx_queue_drained", rx_exp.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
